// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int C_DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int P_REQ_NUM = 4,
  parameter int IDX_W     = $clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [P_REQ_NUM-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  // Wrap by explicit compare so non-power-of-two requester counts work.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(P_REQ_NUM)) cand = cand - (IDX_W+1)'(P_REQ_NUM);
      cand_idx = cand[IDX_W-1:0];
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a UART transmit driver.
// Optional mid-packet idle timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_TIMEOUT_CYCLES  = C_DEFAULT_TIMEOUT
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_uart_tx_data,
  output logic                                   o_uart_tx_valid,
  input  logic                                   i_uart_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy,
  output logic                                   o_timeout
);

  localparam int IDX_W = $clog2(P_REQ_NUM);
  localparam int W     = P_UART_DATA_WIDTH;

  if (P_REQ_NUM < 2 || P_TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: P_REQ_NUM must be >= 2 and P_TIMEOUT_CYCLES >= 1");
  end

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, owner_q, owner_d, ptr_next;
  logic [P_REQ_NUM-1:0] grant_q, grant_d, pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [W-1:0]         req_byte [P_REQ_NUM];
  logic                 own_valid, own_last, handshake, to_hit;

  for (genvar k = 0; k < P_REQ_NUM; k++) begin : g_unpack
    assign req_byte[k] = i_req_data[k*W +: W];
  end

  rr_pick #(
    .P_REQ_NUM (P_REQ_NUM),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req (i_req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_valid = i_req_valid[owner_q];
  assign own_last  = i_req_last[owner_q];
  assign handshake = (state_q == ARB_LOCK) && own_valid && i_uart_tx_ready;
  assign ptr_next  = (owner_q == IDX_W'(P_REQ_NUM - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(P_TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Release on the edge that would bring the idle count to P_TIMEOUT_CYCLES.
  assign to_hit = (state_q == ARB_LOCK) && !own_valid &&
                  (to_cnt_q == TO_W'(P_TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= to_hit;
      if (state_q != ARB_LOCK || own_valid) to_cnt_q <= '0;
      else                                  to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_LOCK;
          grant_d = pick_gnt;
          owner_d = pick_idx;
        end
      end
      ARB_LOCK: begin
        if ((handshake && own_last) || to_hit) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // Locked channel is a pure pass-through so the first byte moves in the grant cycle.
  always_comb begin
    o_req_ready     = '0;
    o_uart_tx_data  = '0;
    o_uart_tx_valid = 1'b0;
    if (state_q == ARB_LOCK) begin
      o_uart_tx_data  = req_byte[owner_q];
      o_uart_tx_valid = own_valid;
      o_req_ready     = grant_q & {P_REQ_NUM{i_uart_tx_ready}};
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q == ARB_LOCK);

endmodule
